// File: rtl/cavlc_bitstream_buf.sv
// cavlc_bitstream_buf
//   Bit-level input stage of the CAVLC decoder. This block takes 32-bit
//   big-endian RBSP words over a valid/ready handshake and stores them in a
//   64-bit shift buffer. The oldest unread bit is always at the MSB. Each
//   cycle the block discards len_comb bits and presents the next 16 unread
//   bits, MSB-aligned, on rbsp.
//
// Ports
//   clk            system clock, rising edge
//   rst_n          asynchronous active-low reset
//   flush          synchronous clear of buffer, fill, error and bit counter
//   data_in        next RBSP word; bit IN_W-1 is first in stream order
//   data_in_valid  data_in holds a word
//   data_in_ready  buffer can take a word (fill <= IN_W), registered-only
//   len_comb       bits to consume this cycle (0..WIN_W)
//   rbsp           next WIN_W unread bits, rbsp[WIN_W-1] oldest
//   rbsp_valid     at least WIN_W unread bits held
//   fill_level     unread bit count (0..BUF_W)
//   bits_consumed  running total of consumed bits, wraps modulo 2^32
//   len_err        sticky flag for an illegal consumption request
module cavlc_bitstream_buf #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned BUF_W = 64,
    parameter int unsigned WIN_W = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           flush,
    input  logic [IN_W-1:0]                data_in,
    input  logic                           data_in_valid,
    output logic                           data_in_ready,
    input  logic [$clog2(WIN_W+1)-1:0]     len_comb,
    output logic [WIN_W-1:0]               rbsp,
    output logic                           rbsp_valid,
    output logic [$clog2(BUF_W+1)-1:0]     fill_level,
    output logic [31:0]                    bits_consumed,
    output logic                           len_err
);

    localparam int unsigned LW = $clog2(WIN_W + 1);
    localparam int unsigned FW = $clog2(BUF_W + 1);

    logic [BUF_W-1:0] shift_buf;
    logic [FW-1:0]    fill_q;

    logic             len_ok;
    logic             err_req;
    logic             push;
    logic [LW-1:0]    len_eff;
    logic [BUF_W-1:0] buf_s;
    logic [FW-1:0]    fill_s;

    // The handshake and window depend only on registered state, so there is
    // no combinational path from len_comb to data_in_ready.
    assign data_in_ready = (fill_q <= FW'(IN_W));
    assign rbsp_valid    = (fill_q >= FW'(WIN_W));
    assign rbsp          = shift_buf[BUF_W-1 -: WIN_W];
    assign fill_level    = fill_q;

    always_comb begin
        len_ok  = (len_comb <= LW'(WIN_W)) && (FW'(len_comb) <= fill_q);
        len_eff = len_ok ? len_comb : '0;
        err_req = (len_comb != '0) && !len_ok;
        push    = data_in_valid && data_in_ready;

        // Consume first, then append the new word directly below the
        // remaining bits. push implies fill_q <= IN_W, so the result fits.
        buf_s  = shift_buf << len_eff;
        fill_s = fill_q - FW'(len_eff);
        if (push) begin
            buf_s  = buf_s | ({data_in, {(BUF_W-IN_W){1'b0}}} >> fill_s);
            fill_s = fill_s + FW'(IN_W);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_buf     <= '0;
            fill_q        <= '0;
            bits_consumed <= '0;
            len_err       <= 1'b0;
        end else if (flush) begin
            shift_buf     <= '0;
            fill_q        <= '0;
            bits_consumed <= '0;
            len_err       <= 1'b0;
        end else begin
            shift_buf     <= buf_s;
            fill_q        <= fill_s;
            bits_consumed <= bits_consumed + 32'(len_eff);
            if (err_req) begin
                len_err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/cavlc_bitstream_buf.md
Name: cavlc_bitstream_buf

Overview:
- Bit-level input stage of the CAVLC decoder.
- Accepts 32-bit big-endian RBSP words through a valid/ready handshake and holds them in a 64-bit shift buffer.
- Presents a 16-bit MSB-aligned window, rbsp, to the CAVLC read stages.
- Each cycle it discards exactly len_comb bits, where len_comb is the per-cycle consumption produced by the length generator.

Parameters:
- IN_W, 32: input word width in bits.
- BUF_W, 64: shift buffer depth in bits; must equal 2*IN_W.
- WIN_W, 16: output window width; also the largest legal per-cycle consumption.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of buffer contents, e.g. at slice start.
- data_in  input  32  next RBSP word; bit 31 is the first bit in stream order.
- data_in_valid  input  1  data_in is valid.
- data_in_ready  output  1  buffer can accept a word this cycle.
- len_comb  input  5  number of bits to consume this cycle (0..16).
- rbsp  output  16  next 16 unread bits; rbsp[15] is the oldest.
- rbsp_valid  output  1  at least 16 unread bits are held.
- fill_level  output  7  unread bit count (0..64).
- bits_consumed  output  32  running total of consumed bits; wraps modulo 2^32.
- len_err  output  1  sticky flag for an illegal consumption request.

Behaviour:
- Reset (rst_n low, asynchronous):
  - buffer, fill_level, bits_consumed and len_err all go to 0.
  - rbsp goes to 0, rbsp_valid to 0, data_in_ready to 1.
- Storage:
  - buf[63:0] is a register; the oldest unread bit is always at buf[63].
  - Bits below the fill point are always zero.
- Registered outputs and derivations:
  - rbsp = buf[63:48]. When fill < 16, the low bits of rbsp read as zero.
  - rbsp_valid = (fill >= 16).
  - data_in_ready = (fill <= 32). It is derived from registered fill only and never from len_comb, so the handshake has no combinational path.
- Consumption:
  - len_eff = len_comb when len_comb <= 16 and len_comb <= fill; otherwise len_eff = 0.
  - len_comb = 0 is always legal.
- Error:
  - len_err is set on any cycle where len_comb != 0 and len_eff = 0.
  - Once set it stays 1 until reset or flush.
  - The offending request consumes nothing.
- Accept: push = data_in_valid & data_in_ready.
- Next-state update, same cycle:
  - Consume first: buf_s = buf << len_eff and fill_s = fill - len_eff.
  - Then append if push: buf_s[63-fill_s -: 32] |= data_in, and fill_s += 32.
  - fill_next = fill_s, which never exceeds 64. The worst case is 32 - 0 + 32.
- Counter: bits_consumed += len_eff.
- Latency:
  - A word accepted at edge N is visible in rbsp/fill_level immediately after edge N.
  - A consumption applied at edge N is reflected in rbsp after edge N.
  - Zero bubble: one consume per cycle at full rate while fill >= 16.
- Flush:
  - Clears buf, fill and len_err after the edge.
  - A push or consume in the same cycle is ignored.
  - bits_consumed is also cleared.
  - Flush has priority over everything except rst_n.
- Simultaneous push and consume at fill = 32 is legal. The resulting fill is 64 - len_eff.
- data_in is ignored when data_in_ready = 0, and the upstream must hold it.
- len_comb of 17..31 is always an error, even if fill >= len_comb.
- Reset mid-operation discards all buffered bits. No partial word is retained.

Test Plan:
- Reset, then push 0xA5C30F11 -> fill_level=32, rbsp=0xA5C3, rbsp_valid=1, data_in_ready=1, bits_consumed=0.
- From that state, len_comb=5 for one cycle -> rbsp=0xB861, fill_level=27, bits_consumed=5; len_err=0.
- Push 0xA5C30F11, then push 0x12345678 with len_comb=16 in the same cycle -> fill_level=48, rbsp=0x0F11. Next cycle len_comb=16 -> rbsp=0x1234, fill=32.
- Back-to-back pushes of 0xFFFFFFFF and 0x00000000 with no consumption -> after the second push fill=64 and data_in_ready=0. A third word is held off. len_comb=16 drops fill to 48 but data_in_ready stays 0; a further len_comb=16 gives fill=32, and data_in_ready rises on the next cycle.
- With fill=3 (rbsp=0b101 followed by zeros, i.e. 0xA000):
  - len_comb=4 -> nothing consumed, len_err=1, fill stays 3.
  - then len_comb=3 -> fill=0, len_err stays 1.
  - then len_comb=20 at fill=32 -> no consumption.
- Flush asserted together with push and len_comb=8 at fill=40 -> after the edge fill=0, rbsp=0, len_err=0, bits_consumed=0. Async rst_n pulse mid-stream immediately zeroes all outputs without waiting for clk.
